// File: rtl/sdram_ctrl_mem.sv
// SDRAM controller behavioural model: request/response handshake backed by an
// internal DEPTH x DATA_W array, with periodic refresh windows that hold off rdy.
module sdram_ctrl_mem #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RD_LAT     = 4,
  parameter int unsigned WR_LAT     = 2,
  parameter int unsigned REF_PERIOD = 780,
  parameter int unsigned REF_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd,
  input  logic [DATA_W/8-1:0] wr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   write_data,
  output logic                rdy,
  output logic                rvalid,
  output logic                wvalid,
  output logic                error,
  output logic [DATA_W-1:0]   read_data
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned REF_W = $clog2(REF_PERIOD);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, REFRESH} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [REF_W-1:0]    ref_cnt_q;
  logic                ref_pending_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   data_q;
  logic [NB-1:0]       mask_q;
  logic                is_rd_q;
  logic                err_q;
  logic                rvalid_q;
  logic                wvalid_q;
  logic                error_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic accept;
  logic bad_req;

  assign rdy     = ~rst & (state_q == IDLE) & ~ref_pending_q;
  assign accept  = rdy & (rd | (|wr));
  assign bad_req = (addr >= ADDR_W'(DEPTH)) | (rd & (|wr));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      rvalid_q      <= 1'b0;
      wvalid_q      <= 1'b0;
      error_q       <= 1'b0;
      rdata_q       <= '0;
    end else begin
      rvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      error_q  <= 1'b0;
      rdata_q  <= '0;
      if (ref_cnt_q == REF_W'(REF_PERIOD - 1)) begin
        ref_cnt_q     <= '0;
        ref_pending_q <= 1'b1;
      end else begin
        ref_cnt_q <= ref_cnt_q + REF_W'(1);
      end
      // Pulses are registered on the RESP->IDLE edge, so BUSY covers LAT-1
      // cycles and the counter is loaded with LAT-2.
      case (state_q)
        IDLE: begin
          if (ref_pending_q) begin
            state_q       <= REFRESH;
            ref_pending_q <= 1'b0;
            cnt_q         <= CNT_W'(REF_CYCLES - 2);
          end else if (accept) begin
            state_q <= BUSY;
            idx_q   <= addr[IDX_W-1:0];
            data_q  <= write_data;
            mask_q  <= wr;
            is_rd_q <= rd;
            err_q   <= bad_req;
            cnt_q   <= bad_req ? '0 :
                       rd      ? CNT_W'(RD_LAT - 2) : CNT_W'(WR_LAT - 2);
          end
        end
        BUSY: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        RESP: begin
          state_q <= IDLE;
          if (err_q) begin
            error_q <= 1'b1;
          end else if (is_rd_q) begin
            rvalid_q <= 1'b1;
            rdata_q  <= mem[idx_q];
          end else begin
            wvalid_q <= 1'b1;
          end
        end
        REFRESH: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write bytes land at the end of the wvalid cycle; the latched request is
  // still intact then because the next acceptance shares this edge.
  always_ff @(posedge clk) begin
    if (wvalid_q) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (mask_q[b]) mem[idx_q][b*8 +: 8] <= data_q[b*8 +: 8];
      end
    end
  end

  assign rvalid    = rvalid_q;
  assign wvalid    = wvalid_q;
  assign error     = error_q;
  assign read_data = rdata_q;

endmodule

// File: tb/tb_sdram_ctrl_mem.sv
// Directed bench for sdram_ctrl_mem: requests push expected responses to a
// scoreboard that a negedge monitor pops and checks against a memory model.
module tb_sdram_ctrl_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd;
  logic [3:0]  wr;
  logic [23:0] addr;
  logic [31:0] write_data;
  logic        rdy, rvalid, wvalid, error;
  logic [31:0] read_data;

  sdram_ctrl_mem #(
    .ADDR_W(24), .DATA_W(32), .DEPTH(1024), .RD_LAT(4), .WR_LAT(2),
    .REF_PERIOD(780), .REF_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr),
    .write_data(write_data), .rdy(rdy), .rvalid(rvalid), .wvalid(wvalid),
    .error(error), .read_data(read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;  // 0 read, 1 write, 2 error
    int          addr;
    logic [31:0] data;
    logic [3:0]  mask;
    int          due;
  } entry_t;

  entry_t      sb[$];
  logic [31:0] mdl [0:1023];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive a request (caller is at a negedge), hold it until rdy, record acceptance.
  task automatic do_req(input logic r, input logic [3:0] m, input int a,
                        input logic [31:0] d, input bit hold, output int acc);
    entry_t e;
    int n = 0;
    rd = r; wr = m; addr = 24'(a); write_data = d;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      chk("accept_timeout", 0, 1);
      acc = -1;
      rd = 1'b0; wr = '0;
      return;
    end
    acc    = cyc + 1;
    e.kind = (a >= 1024 || (r && m != 0)) ? 2 : (r ? 0 : 1);
    e.addr = a; e.data = d; e.mask = m;
    e.due  = acc + (e.kind == 2 ? 2 : (r ? 4 : 2));
    sb.push_back(e);
    @(negedge clk);
    if (!hold) begin
      rd = 1'b0; wr = '0;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    entry_t e;
    bit     due_now;
    int     got;
    if (!rst) begin
      chk("onehot", 64'($countones({rvalid, wvalid, error}) <= 1), 1);
      if (!rvalid) chk("rdata_idle", read_data, 0);
      due_now = (sb.size() > 0) && (sb[0].due == cyc);
      chk("pulse_timing", rvalid | wvalid | error, due_now);
      if (due_now) begin
        e   = sb.pop_front();
        got = rvalid ? 0 : wvalid ? 1 : error ? 2 : 3;
        chk("resp_kind", 64'(got), 64'(e.kind));
        if (rvalid && e.kind == 0) chk("read_data", read_data, mdl[e.addr]);
        if (wvalid && e.kind == 1) begin
          for (int b = 0; b < 4; b++)
            if (e.mask[b]) mdl[e.addr][b*8 +: 8] = e.data[b*8 +: 8];
        end
      end
    end
  end

  initial begin
    int c0, a0, a1, a2;
    rst = 1'b1; rd = 1'b0; wr = '0; addr = '0; write_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_error", error, 0);
    chk("rst_rdata", read_data, 0);
    rst = 1'b0;
    c0 = cyc;
    @(negedge clk);
    chk("rdy_after_rst", rdy, 1);

    // Full write then read back; next acceptance is LAT+1 after the write.
    do_req(1'b0, 4'hF, 5, 32'hDEADBEEF, 0, a0);
    do_req(1'b1, 4'h0, 5, 32'h0, 0, a1);
    chk("w2r_gap", 64'(a1 - a0), 3);
    // Partial write then read.
    do_req(1'b0, 4'h3, 5, 32'h11223344, 0, a0);
    do_req(1'b1, 4'h0, 5, 32'h0, 0, a1);
    // Errors: out of range read, and read+write together (memory must not change).
    do_req(1'b1, 4'h0, 1024, 32'h0, 0, a0);
    do_req(1'b1, 4'h1, 5, 32'hFFFFFFFF, 0, a0);
    do_req(1'b1, 4'h0, 5, 32'h0, 0, a0);
    // Second address with another pattern, boundary address DEPTH-1.
    do_req(1'b0, 4'hF, 1023, 32'hA5A55A5A, 0, a0);
    do_req(1'b0, 4'hC, 1023, 32'h0F0F0F0F, 0, a0);
    do_req(1'b1, 4'h0, 1023, 32'h0, 0, a0);
    // Back-to-back reads with rd held high.
    do_req(1'b1, 4'h0, 5, 32'h0, 1, a0);
    do_req(1'b1, 4'h0, 5, 32'h0, 1, a1);
    do_req(1'b1, 4'h0, 1023, 32'h0, 0, a2);
    chk("b2b_gap1", 64'(a1 - a0), 5);
    chk("b2b_gap2", 64'(a2 - a1), 5);

    // Refresh while idle: rdy low for cycles c0+780..c0+787, held read waits.
    wait_cyc(c0 + 779);
    chk("ref1_pre", rdy, 1);
    wait_cyc(c0 + 780);
    chk("ref1_start", rdy, 0);
    wait_cyc(c0 + 781);
    do_req(1'b1, 4'h0, 5, 32'h0, 0, a0);
    chk("ref1_held_accept", 64'(a0 - c0), 789);

    // Refresh with a read in flight at the wrap (c0+1560).
    wait_cyc(c0 + 1557);
    do_req(1'b1, 4'h0, 1023, 32'h0, 0, a0);
    chk("ref2_accept", 64'(a0 - c0), 1558);
    wait_cyc(c0 + 1562);
    chk("ref2_rdy_after_resp", rdy, 0);
    wait_cyc(c0 + 1569);
    chk("ref2_rdy_last_low", rdy, 0);
    wait_cyc(c0 + 1570);
    chk("ref2_rdy_back", rdy, 1);

    // Reset one cycle after a write acceptance aborts it.
    do_req(1'b0, 4'hF, 5, 32'hCAFEF00D, 0, a0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    chk("midrst_rdy", rdy, 0);
    chk("midrst_wvalid", wvalid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_midrst", rdy, 1);
    do_req(1'b1, 4'h0, 5, 32'h0, 0, a0);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
